// File: rtl/ac_dispatch_pkg.sv
// Shared types for the multi-lane access-control dispatcher: FSM states and
// the lane-index width helper.
package ac_dispatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // A lane pointer needs at least one bit even for the minimum of two lanes.
    function automatic int lane_idx_w(input int n_lanes);
        return (n_lanes > 2) ? $clog2(n_lanes) : 1;
    endfunction

endpackage

// File: rtl/ac_lane_credit.sv
// Per-lane outstanding-beat counter; credit_ok stays high while the lane can
// take another beat without exceeding MAX_OUTSTAND in flight.
module ac_lane_credit #(
    parameter int MAX_OUTSTAND = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    input  logic dec,
    output logic credit_ok
);

    localparam int CW = $clog2(MAX_OUTSTAND + 1);

    logic [CW-1:0] outstanding;

    // Simultaneous dispatch and return on this lane leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            outstanding <= '0;
        end else if (inc && !dec) begin
            outstanding <= outstanding + CW'(1);
        end else if (dec && !inc) begin
            outstanding <= outstanding - CW'(1);
        end
    end

    assign credit_ok = (outstanding < CW'(MAX_OUTSTAND));

endmodule

// File: rtl/ac_lane_dispatch.sv
// Round-robin dispatch of one AXI-Stream frame over N_LANES PEs with in-order
// collection and framing checks. Define AC_LANE_STATS_EN for per-lane beat counters.
module ac_lane_dispatch
    import ac_dispatch_pkg::*;
#(
    parameter int DATA_WIDTH     = 24,
    parameter int OUT_WIDTH      = 96,
    parameter int N_LANES        = 4,
    parameter int MAX_OUTSTAND   = 4,
    parameter int SRC_IMG_WIDTH  = 960,
    parameter int SRC_IMG_HEIGHT = 540
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_start,
    output logic                         busy,
    output logic                         done,
    output logic                         err_sof,
    output logic                         err_eol,
    input  logic                         s_axis_tvalid,
    output logic                         s_axis_tready,
    input  logic [DATA_WIDTH-1:0]        s_axis_tdata,
    input  logic                         s_axis_tuser,
    input  logic                         s_axis_tlast,
    output logic [N_LANES-1:0]           lane_vld,
    input  logic [N_LANES-1:0]           lane_rdy,
    output logic [DATA_WIDTH-1:0]        lane_data,
    input  logic [N_LANES-1:0]           lane_res_vld,
    output logic [N_LANES-1:0]           lane_res_rdy,
    input  logic [N_LANES*OUT_WIDTH-1:0] lane_res_data,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [OUT_WIDTH-1:0]         m_axis_tdata,
    output logic                         m_axis_tuser,
    output logic                         m_axis_tlast,
    output logic [N_LANES*32-1:0]        stat_beats
);

    localparam int FRAME_PIX = SRC_IMG_WIDTH * SRC_IMG_HEIGHT;
    localparam int CNT_W     = $clog2(FRAME_PIX + 1);
    localparam int LANE_W    = lane_idx_w(N_LANES);
    localparam int COL_W     = (SRC_IMG_WIDTH > 1) ? $clog2(SRC_IMG_WIDTH) : 1;

    state_e               state, state_nxt;
    logic [LANE_W-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     in_cnt, out_cnt, ld_cnt;
    logic [COL_W-1:0]     col;
    logic [N_LANES-1:0]   credit_ok, lane_inc, lane_dec;
    logic [OUT_WIDTH-1:0] res_sel;
    logic                 run, start_acc, sel_credit, in_hs, res_hs, m_hs, out_free;

    function automatic logic [LANE_W-1:0] next_lane(input logic [LANE_W-1:0] p);
        return (p == LANE_W'(N_LANES - 1)) ? '0 : p + LANE_W'(1);
    endfunction

    assign run           = (state == RUN);
    assign busy          = (state != IDLE);
    assign done          = (state == DONE);
    assign start_acc     = (state == IDLE) && cfg_start;
    assign sel_credit    = credit_ok[wr_ptr];
    assign s_axis_tready = run && sel_credit && lane_rdy[wr_ptr];
    assign in_hs         = s_axis_tvalid && s_axis_tready;
    assign out_free      = !m_axis_tvalid || m_axis_tready;
    assign res_hs        = |lane_dec;
    assign m_hs          = m_axis_tvalid && m_axis_tready;
    assign lane_data     = s_axis_tdata;

    always_comb begin
        lane_vld     = '0;
        lane_res_rdy = '0;
        lane_inc     = '0;
        lane_dec     = '0;
        res_sel      = '0;
        for (int i = 0; i < N_LANES; i++) begin
            lane_vld[i]     = (LANE_W'(i) == wr_ptr) && s_axis_tvalid && run && sel_credit;
            lane_res_rdy[i] = (LANE_W'(i) == rd_ptr) && out_free && busy;
            lane_inc[i]     = lane_vld[i] && lane_rdy[i];
            lane_dec[i]     = lane_res_rdy[i] && lane_res_vld[i];
            if (LANE_W'(i) == rd_ptr) begin
                res_sel = lane_res_data[i*OUT_WIDTH +: OUT_WIDTH];
            end
        end
    end

    for (genvar g = 0; g < N_LANES; g++) begin : g_credit
        ac_lane_credit #(
            .MAX_OUTSTAND(MAX_OUTSTAND)
        ) u_credit (
            .clk      (clk),
            .rst      (rst),
            .clr      (start_acc),
            .inc      (lane_inc[g]),
            .dec      (lane_dec[g]),
            .credit_ok(credit_ok[g])
        );
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg_start) state_nxt = RUN;
            RUN:     if (in_hs && (in_cnt == CNT_W'(FRAME_PIX - 1))) state_nxt = DRAIN;
            DRAIN:   if ((out_cnt == CNT_W'(FRAME_PIX)) && !m_axis_tvalid) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Dispatch/collect bookkeeping; framing errors are sticky until the next start.
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
            ld_cnt  <= '0;
            col     <= '0;
            err_sof <= 1'b0;
            err_eol <= 1'b0;
        end else begin
            if (in_hs) begin
                wr_ptr  <= next_lane(wr_ptr);
                in_cnt  <= in_cnt + CNT_W'(1);
                col     <= (col == COL_W'(SRC_IMG_WIDTH - 1)) ? '0 : col + COL_W'(1);
                err_sof <= err_sof || (s_axis_tuser != (in_cnt == '0));
                err_eol <= err_eol || (s_axis_tlast != (col == COL_W'(SRC_IMG_WIDTH - 1)));
            end
            if (res_hs) begin
                rd_ptr <= next_lane(rd_ptr);
                ld_cnt <= ld_cnt + CNT_W'(1);
            end
            if (m_hs) begin
                out_cnt <= out_cnt + CNT_W'(1);
            end
        end
    end

    // Output register: loads the selected lane result, holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else if (res_hs) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= res_sel;
            m_axis_tuser  <= (ld_cnt == '0);
            m_axis_tlast  <= (ld_cnt == CNT_W'(FRAME_PIX - 1));
        end else if (m_hs) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef AC_LANE_STATS_EN
    logic [31:0] stat_q [N_LANES];

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_LANES; i++) begin
            if (rst || start_acc)  stat_q[i] <= '0;
            else if (lane_inc[i])  stat_q[i] <= stat_q[i] + 32'd1;
        end
    end

    always_comb begin
        stat_beats = '0;
        for (int i = 0; i < N_LANES; i++) begin
            stat_beats[i*32 +: 32] = stat_q[i];
        end
    end
`else
    assign stat_beats = '0;
`endif

endmodule

// File: tb/tb_ac_lane_dispatch.sv
// Bench for ac_lane_dispatch: 4 lanes, 2 credits, 8x2 frame; lane models echo a
// lane-tagged result, a scoreboard holds expected output beats in input order.
module tb_ac_lane_dispatch;

    localparam int DW = 24;
    localparam int OW = 96;
    localparam int NL = 4;
    localparam int MO = 2;
    localparam int FP = 16;

    logic            clk, rst, cfg_start;
    logic            busy, done, err_sof, err_eol;
    logic            s_axis_tvalid, s_axis_tready, s_axis_tuser, s_axis_tlast;
    logic [DW-1:0]   s_axis_tdata;
    logic [NL-1:0]   lane_vld, lane_rdy, lane_res_vld, lane_res_rdy;
    logic [DW-1:0]   lane_data;
    logic [NL*OW-1:0] lane_res_data;
    logic            m_axis_tvalid, m_axis_tready, m_axis_tuser, m_axis_tlast;
    logic [OW-1:0]   m_axis_tdata;
    logic [NL*32-1:0] stat_beats;

    ac_lane_dispatch #(
        .DATA_WIDTH(DW), .OUT_WIDTH(OW), .N_LANES(NL), .MAX_OUTSTAND(MO),
        .SRC_IMG_WIDTH(8), .SRC_IMG_HEIGHT(2)
    ) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .busy(busy), .done(done),
        .err_sof(err_sof), .err_eol(err_eol),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
        .lane_vld(lane_vld), .lane_rdy(lane_rdy), .lane_data(lane_data),
        .lane_res_vld(lane_res_vld), .lane_res_rdy(lane_res_rdy), .lane_res_data(lane_res_data),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .stat_beats(stat_beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [OW-1:0] d;
        logic          u;
        logic          l;
    } exp_t;

    typedef struct {
        int   sof_bad;
        int   eol_bad;
        int   hold_lane;
        int   stall_at;
        logic exp_sof;
        logic exp_eol;
        int   exp_out;
        int   exp_block;
        int   exp_occ;
    } vec_t;

    int total = 0;
    int bad   = 0;

    exp_t          sb[$];
    exp_t          e;
    logic [DW-1:0] tx_data [FP];
    logic          tx_user [FP];
    logic          tx_last [FP];
    int            tx_idx, n_out, n_done, first_block, max_occ;
    bit            tx_on;
    logic [DW-1:0] lbuf [NL][8];
    int            lhead [NL];
    int            lcnt  [NL];
    int            hold_lane, hold_cycles, stall_at, stall_left;
    bit            stall_started, held_v;
    logic [OW-1:0] held_d;
    logic          in_hs_s, m_hs_s;
    logic [NL-1:0] lhs_s, rhs_s;
    logic [DW-1:0] lane_data_s;
    logic [NL*32-1:0] exp_stats;
    vec_t          vecs [5];

    function automatic logic [OW-1:0] lane_fn(input logic [DW-1:0] d, input int lane);
        return {8'(lane), d, ~d, d ^ 24'h5A5A5A, 16'hC3A5};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive();
        if (tx_on && tx_idx < FP) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = tx_data[tx_idx];
            s_axis_tuser  = tx_user[tx_idx];
            s_axis_tlast  = tx_last[tx_idx];
        end else begin
            s_axis_tvalid = 1'b0;
            s_axis_tdata  = '0;
            s_axis_tuser  = 1'b0;
            s_axis_tlast  = 1'b0;
        end
        lane_rdy = '1;
        for (int i = 0; i < NL; i++) begin
            lane_res_vld[i] = (lcnt[i] > 0) && !(i == hold_lane && hold_cycles > 0);
            lane_res_data[i*OW +: OW] = (lcnt[i] > 0) ? lane_fn(lbuf[i][lhead[i]], i) : '0;
        end
        m_axis_tready = (stall_left == 0);
    endtask

    task automatic clear_lanes();
        for (int i = 0; i < NL; i++) begin
            lhead[i] = 0;
            lcnt[i]  = 0;
        end
        sb.delete();
    endtask

    // One clock: sample handshakes and check outputs at negedge, update models after posedge.
    task automatic tick();
        @(negedge clk);
        in_hs_s     = s_axis_tvalid & s_axis_tready;
        m_hs_s      = m_axis_tvalid & m_axis_tready;
        lhs_s       = lane_vld & lane_rdy;
        rhs_s       = lane_res_vld & lane_res_rdy;
        lane_data_s = lane_data;
        if (m_hs_s) begin
            if (sb.size() == 0) begin
                check("extra_out_beat", 1, 0);
            end else begin
                e = sb.pop_front();
                check("out_data", m_axis_tdata, e.d);
                check("out_tuser", m_axis_tuser, e.u);
                check("out_tlast", m_axis_tlast, e.l);
            end
            n_out++;
        end
        if (done) n_done++;
        if (busy && s_axis_tvalid && !s_axis_tready && first_block < 0) first_block = tx_idx;
        if (stall_left > 0 && m_axis_tvalid) begin
            check("stall_res_rdy", lane_res_rdy, 0);
            if (held_v) check("stall_hold_data", m_axis_tdata, held_d);
            held_v = 1'b1;
            held_d = m_axis_tdata;
        end else begin
            held_v = 1'b0;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NL; i++) begin
            if (rhs_s[i]) begin
                lhead[i] = (lhead[i] + 1) % 8;
                lcnt[i]--;
            end
            if (lhs_s[i]) begin
                lbuf[i][(lhead[i] + lcnt[i]) % 8] = lane_data_s;
                lcnt[i]++;
                if (lcnt[i] > max_occ) max_occ = lcnt[i];
            end
        end
        if (in_hs_s && tx_idx < FP) begin
            sb.push_back('{d: lane_fn(tx_data[tx_idx], tx_idx % NL), u: (tx_idx == 0), l: (tx_idx == FP - 1)});
            tx_idx++;
        end
        if (hold_cycles > 0) hold_cycles--;
        if (stall_left > 0) stall_left--;
        if (stall_at >= 0 && n_out == stall_at && !stall_started) begin
            stall_left    = 10;
            stall_started = 1'b1;
        end
        drive();
    endtask

    task automatic frame_start(input vec_t v);
        for (int k = 0; k < FP; k++) begin
            tx_data[k] = DW'($urandom);
            tx_user[k] = (k == 0) || (k == v.sof_bad);
            tx_last[k] = (k % 8 == 7) || (k == v.eol_bad);
        end
        tx_idx = 0; n_out = 0; n_done = 0; first_block = -1; max_occ = 0;
        hold_lane     = v.hold_lane;
        hold_cycles   = (v.hold_lane >= 0) ? 40 : 0;
        stall_at      = v.stall_at;
        stall_left    = 0;
        stall_started = 1'b0;
        held_v        = 1'b0;
        tx_on         = 1'b1;
        cfg_start     = 1'b1;
        drive();
        tick();
        cfg_start = 1'b0;
        check("start_busy", busy, 1);
        check("start_err_sof_clr", err_sof, 0);
        check("start_err_eol_clr", err_eol, 0);
    endtask

    task automatic run_frame(input vec_t v);
        frame_start(v);
        for (int c = 0; c < 300 && n_done == 0; c++) tick();
        for (int c = 0; c < 3; c++) tick();
        tx_on = 1'b0;
        check("frame_out_count", n_out, v.exp_out);
        check("frame_done_pulses", n_done, 1);
        check("frame_sb_empty", sb.size(), 0);
        check("frame_err_sof", err_sof, v.exp_sof);
        check("frame_err_eol", err_eol, v.exp_eol);
        check("frame_busy_low", busy, 0);
        check("frame_max_occ", max_occ, v.exp_occ);
        if (v.exp_block != -2) check("frame_first_block", first_block, v.exp_block);
        check("frame_stat_beats", stat_beats, exp_stats);
    endtask

    initial begin
`ifdef AC_LANE_STATS_EN
        exp_stats = {32'd4, 32'd4, 32'd4, 32'd4};
`else
        exp_stats = '0;
`endif
        //          sof eol hold stall esof eeol out block occ
        vecs[0] = '{-1, -1, -1, -1, 1'b0, 1'b0, 16, -1, 1};
        vecs[1] = '{-1, -1,  2, -1, 1'b0, 1'b0, 16, 10, 2};
        vecs[2] = '{-1, -1, -1,  5, 1'b0, 1'b0, 16, -2, 2};
        vecs[3] = '{ 5,  3, -1, -1, 1'b1, 1'b1, 16, -1, 1};
        vecs[4] = '{-1, -1, -1, -1, 1'b0, 1'b0, 16, -1, 1};

        rst = 1'b1; cfg_start = 1'b0; tx_on = 1'b0; tx_idx = 0;
        hold_lane = -1; hold_cycles = 0; stall_at = -1; stall_left = 0;
        clear_lanes();
        drive();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_errs", {err_sof, err_eol}, 0);
        check("rst_m_axis", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}, 0);
        check("rst_s_ready", s_axis_tready, 0);
        check("rst_stats", stat_beats, 0);

        for (int r = 0; r < 5; r++) run_frame(vecs[r]);

        // Reset in the middle of a frame, then a clean frame.
        frame_start(vecs[0]);
        for (int c = 0; c < 100 && tx_idx < 9; c++) tick();
        check("midrst_reached_beat9", tx_idx, 9);
        tx_on = 1'b0;
        rst   = 1'b1;
        tick();
        clear_lanes();
        drive();
        check("midrst_ctrl", {busy, done, err_sof, err_eol, s_axis_tready}, 0);
        check("midrst_lanes", {lane_vld, lane_res_rdy, lane_data}, 0);
        check("midrst_m_axis", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}, 0);
        check("midrst_stats", stat_beats, 0);
        rst = 1'b0;
        tick();
        run_frame(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
